// File: rtl/sift_seq_pkg.sv
// Shared types and constants for the SIFT stage sequencer.
package sift_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_TMO   = 2'd1;
    localparam logic [1:0] ERR_ABORT = 2'd2;

    // ceil(log2(n)), never below 1 so a single-stage build still has an index bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sift_stage_sequencer_next_stage_find.sv
// Finds the lowest enabled stage index strictly above the current one
// (or the lowest enabled index overall when searching from the start).
module next_stage_find #(
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = 2
) (
    input  logic [NUM_STAGES-1:0] en_i,
    input  logic [SEL_W-1:0]      cur_i,
    input  logic                  from_start_i,
    output logic [SEL_W-1:0]      nxt_o,
    output logic                  valid_o
);

    always_comb begin
        nxt_o   = '0;
        valid_o = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (en_i[i] && (from_start_i || (i > int'(cur_i)))) begin
                nxt_o   = SEL_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sift_stage_sequencer.sv
// Stage sequencer: runs enabled stages in index order with a one-cycle gap,
// per-stage watchdog, abort, and a muxed view of the active stage's SRAM port.
module sift_stage_sequencer
    import sift_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int NUM_MEM    = 4,
    parameter int ADDR_W     = 9,
    parameter int TMO_W      = 24,
    parameter int SEL_W      = clog2_min1(NUM_STAGES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  logic [NUM_STAGES-1:0]              stage_en_i,
    input  logic [TMO_W-1:0]                   tmo_limit_i,
    input  logic [NUM_STAGES-1:0]              stage_done_i,
    input  logic [NUM_STAGES*NUM_MEM*ADDR_W-1:0] stage_addr_i,
    input  logic [NUM_STAGES-1:0]              stage_bwe_i,
    output logic [NUM_STAGES-1:0]              stage_start_o,
    output logic [NUM_MEM*ADDR_W-1:0]          mem_addr_o,
    output logic                               buffer_we_o,
    output logic [SEL_W-1:0]                   active_stage_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               error_o,
    output logic [1:0]                         err_code_o,
    output logic [31:0]                        run_cycles_o
);

    localparam int PORT_W = NUM_MEM * ADDR_W;

    state_e                state_q;
    logic [NUM_STAGES-1:0] en_q, start_q;
    logic [SEL_W-1:0]      active_q, first_idx, nxt_idx;
    logic                  first_vld, nxt_vld;
    logic                  busy_q, done_q, error_q;
    logic [1:0]            err_q;
    logic [31:0]           cyc_q;
    logic [TMO_W-1:0]      wdog_q;
    logic                  accept, tmo_hit;

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_STAGES-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // First stage is chosen from the live mask since en_q is loaded on the same edge
    next_stage_find #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_first (
        .en_i(stage_en_i), .cur_i('0), .from_start_i(1'b1),
        .nxt_o(first_idx), .valid_o(first_vld)
    );

    next_stage_find #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_next (
        .en_i(en_q), .cur_i(active_q), .from_start_i(1'b0),
        .nxt_o(nxt_idx), .valid_o(nxt_vld)
    );

    assign accept  = start_i && ((state_q == S_IDLE) || ((state_q == S_ERROR) && !abort_i));
    assign tmo_hit = (tmo_limit_i != '0) && (wdog_q == tmo_limit_i - TMO_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            en_q     <= '0;
            start_q  <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            err_q    <= ERR_NONE;
            cyc_q    <= '0;
            wdog_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && (cyc_q != '1)) cyc_q <= cyc_q + 32'd1;

            if (accept) begin
                en_q    <= stage_en_i;
                err_q   <= ERR_NONE;
                cyc_q   <= '0;
                error_q <= 1'b0;
                wdog_q  <= '0;
                if (first_vld) begin
                    state_q  <= S_RUN;
                    active_q <= first_idx;
                    start_q  <= onehot(first_idx);
                    busy_q   <= 1'b1;
                end else begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_RUN, S_GAP, S_DONE: begin
                        if (abort_i) begin
                            state_q <= S_IDLE;
                            start_q <= '0;
                            busy_q  <= 1'b0;
                            err_q   <= ERR_ABORT;
                        end else if (state_q == S_DONE) begin
                            state_q <= S_IDLE;
                        end else if (state_q == S_GAP) begin
                            state_q  <= S_RUN;
                            active_q <= nxt_idx;
                            start_q  <= onehot(nxt_idx);
                            wdog_q   <= '0;
                        end else if (stage_done_i[active_q]) begin
                            start_q <= '0;
                            if (nxt_vld) begin
                                state_q <= S_GAP;
                            end else begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else if (tmo_hit) begin
                            state_q <= S_ERROR;
                            start_q <= '0;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                            err_q   <= ERR_TMO;
                        end else begin
                            wdog_q <= wdog_q + TMO_W'(1);
                        end
                    end
                    S_ERROR: begin
                        if (abort_i) begin
                            state_q <= S_IDLE;
                            error_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        buffer_we_o = 1'b0;
        if (state_q == S_RUN) begin
            mem_addr_o  = stage_addr_i[int'(active_q) * PORT_W +: PORT_W];
            buffer_we_o = stage_bwe_i[active_q];
        end
    end

    assign stage_start_o  = start_q;
    assign active_stage_o = active_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign err_code_o     = err_q;
    assign run_cycles_o   = cyc_q;

endmodule

// File: tb/tb_sift_stage_sequencer.sv
// Directed plus randomized bench for sift_stage_sequencer; expected sequences,
// latencies and cycle counts come from a per-run model of the stage rules.
module tb_sift_stage_sequencer;

    localparam int NS = 3;
    localparam int NM = 4;
    localparam int AW = 9;
    localparam int TW = 24;
    localparam int SW = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start, abort;
    logic [NS-1:0]       stage_en, stage_done, stage_bwe;
    logic [TW-1:0]       tmo_limit;
    logic [NS*NM*AW-1:0] stage_addr;
    logic [NS-1:0]       stage_start;
    logic [NM*AW-1:0]    mem_addr;
    logic                buffer_we, busy, done, error;
    logic [SW-1:0]       active_stage;
    logic [1:0]          err_code;
    logic [31:0]         run_cycles;

    logic [NS-1:0] resp_done, force_done;
    int            dly[NS];
    int            cnt[NS];
    int            total = 0;
    int            bad = 0;
    int            prev_act = 0;

    always #5 clk = ~clk;

    sift_stage_sequencer #(.NUM_STAGES(NS), .NUM_MEM(NM), .ADDR_W(AW), .TMO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .stage_en_i(stage_en), .tmo_limit_i(tmo_limit), .stage_done_i(stage_done),
        .stage_addr_i(stage_addr), .stage_bwe_i(stage_bwe),
        .stage_start_o(stage_start), .mem_addr_o(mem_addr), .buffer_we_o(buffer_we),
        .active_stage_o(active_stage), .busy_o(busy), .done_o(done), .error_o(error),
        .err_code_o(err_code), .run_cycles_o(run_cycles)
    );

    // Stage responder: raises done on the dly[s]-th cycle of a started level (0 = never)
    assign stage_done = resp_done | force_done;
    always @(negedge clk) begin
        for (int s = 0; s < NS; s++) begin
            cnt[s]       = stage_start[s] ? cnt[s] + 1 : 0;
            resp_done[s] = (dly[s] != 0) && (cnt[s] == dly[s]);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NM*AW-1:0] exp_addr(input int s);
        logic [NM*AW-1:0] r;
        r = '0;
        for (int m = 0; m < NM; m++) r[m*AW +: AW] = AW'(16 * s + m);
        return r;
    endfunction

    task automatic run_case(input logic [NS-1:0] en, input int d0, input int d1, input int d2,
                            input int tmo);
        int d[NS];
        int exp_list[$];
        int got[$];
        int exp_cyc, exp_act, j, idx;
        bit exp_err, seen;
        logic [NS-1:0] prev_ss, rise, bwe;
        d[0] = d0; d[1] = d1; d[2] = d2;
        exp_cyc = 0; exp_err = 0; exp_act = prev_act;
        for (int s = 0; s < NS; s++) begin
            if (en[s] && !exp_err) begin
                if (exp_list.size() > 0) exp_cyc++;
                exp_list.push_back(s);
                exp_act = s;
                if (tmo != 0 && (d[s] == 0 || d[s] > tmo)) begin
                    exp_cyc += tmo;
                    exp_err = 1;
                end else begin
                    exp_cyc += d[s];
                end
            end
        end
        for (int s = 0; s < NS; s++) dly[s] = d[s];
        bwe       = NS'($urandom_range(0, 7));
        stage_bwe = bwe;
        stage_en  = en;
        tmo_limit = TW'(tmo);
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        stage_en = ~en;
        prev_ss = '0; seen = 0; j = 0;
        while (!seen && j < 400) begin
            @(negedge clk);
            j++;
            start = (j == 2) && busy;
            rise = stage_start & ~prev_ss;
            prev_ss = stage_start;
            for (int s = 0; s < NS; s++) if (rise[s]) got.push_back(s);
            if (stage_start != '0) begin
                idx = 0;
                for (int s = 0; s < NS; s++) if (stage_start[s]) idx = s;
                chk("run_onehot", $onehot(stage_start), 1);
                chk("run_active", active_stage, idx);
                chk("run_addr", mem_addr, exp_addr(idx));
                chk("run_bwe", buffer_we, bwe[idx]);
            end else begin
                chk("off_addr", mem_addr, 0);
                chk("off_bwe", buffer_we, 0);
            end
            seen = done || error;
        end
        start = 1'b0;
        chk("end_reached", seen, 1);
        chk("latency", j, exp_cyc + 1);
        chk("done", done, !exp_err);
        chk("error", error, exp_err);
        chk("err_code", err_code, exp_err ? 1 : 0);
        chk("active_end", active_stage, exp_act);
        chk("run_cycles", run_cycles, exp_cyc);
        chk("starts_n", got.size(), exp_list.size());
        for (int i = 0; i < got.size() && i < exp_list.size(); i++)
            chk("starts_idx", got[i], exp_list[i]);
        @(negedge clk);
        if (!exp_err) begin
            chk("done_once", done, 0);
            chk("post_busy", busy, 0);
        end else begin
            chk("err_hold", error, 1);
        end
        chk("cyc_hold", run_cycles, exp_cyc);
        prev_act = exp_act;
    endtask

    initial begin
        int j;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stage_en = '0; stage_bwe = '0;
        tmo_limit = '0; force_done = '0;
        for (int s = 0; s < NS; s++)
            for (int m = 0; m < NM; m++) stage_addr[(s*NM+m)*AW +: AW] = AW'(16 * s + m);
        repeat (2) @(negedge clk);
        chk("rst_start", stage_start, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_bwe", buffer_we, 0);
        chk("rst_active", active_stage, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_errcode", err_code, 0);
        chk("rst_cycles", run_cycles, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_case(3'b111, 10, 10, 10, 0);
        run_case(3'b101, 4, 4, 4, 0);
        run_case(3'b000, 1, 1, 1, 0);
        run_case(3'b111, 3, 0, 6, 5);
        run_case(3'b111, 2, 3, 4, 0);
        run_case(3'b010, 0, 0, 0, 4);

        // abort out of ERROR keeps the timeout code
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("err_abort_error", error, 0);
        chk("err_abort_code", err_code, 1);
        chk("err_abort_busy", busy, 0);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_code", err_code, 1);
        chk("idle_abort_busy", busy, 0);

        // abort wins over a simultaneous done on the last stage
        dly[0] = 2; dly[1] = 2; dly[2] = 0;
        stage_en = 3'b111; tmo_limit = '0; stage_bwe = 3'b111;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        j = 0;
        while (!stage_start[2] && j < 50) begin
            @(negedge clk);
            j++;
        end
        chk("abort_reach", stage_start[2], 1);
        @(negedge clk);
        chk("abort_addr_run", mem_addr, exp_addr(2));
        force_done = 3'b100;
        abort = 1'b1;
        @(posedge clk); #1;
        force_done = '0;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_start", stage_start, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_code", err_code, 2);
        chk("abort_active", active_stage, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
        end
        prev_act = 2;

        for (int r = 0; r < 10; r++) begin
            int tm;
            int dd[NS];
            logic [NS-1:0] e;
            tm = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
            for (int s = 0; s < NS; s++)
                dd[s] = (tm == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
            e = NS'($urandom_range(0, 7));
            run_case(e, dd[0], dd[1], dd[2], tm);
        end

        // asynchronous reset in the middle of a stage
        dly[0] = 30; dly[1] = 30; dly[2] = 30;
        stage_en = 3'b111; tmo_limit = '0; stage_bwe = 3'b111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_start", stage_start, 3'b001);
        chk("pre_rst_addr", mem_addr, exp_addr(0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_start", stage_start, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_bwe", buffer_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cycles", run_cycles, 0);
        chk("mid_rst_active", active_stage, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
